// File: rtl/vga_sprite_mixer.sv
// rtl/vga_sprite_mixer.sv - two-stage sprite-over-checkerboard pixel compositor
// Optional collision flag: define COLLISION_DETECT_EN.
module vga_sprite_mixer #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_SIZE = 32,
  parameter int COL_W       = 12,
  parameter int ROW_W       = 11,
  parameter int CHECKER_BIT = 7
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [COL_W-1:0]         display_col_i,
  input  logic [ROW_W-1:0]         display_row_i,
  input  logic                     visible_i,
  input  logic                     hsync_i,
  input  logic                     vsync_i,
  input  logic [NUM_SPRITES-1:0]   sprite_en_i,
  input  logic [NUM_SPRITES*COL_W-1:0] sprite_x_i,
  input  logic [NUM_SPRITES*ROW_W-1:0] sprite_y_i,
  input  logic [NUM_SPRITES*15-1:0]    sprite_color_i,
  input  logic [8:0]               bg_tint_i,
  output logic [7:0]               vga_r_o,
  output logic [7:0]               vga_g_o,
  output logic [7:0]               vga_b_o,
  output logic                     vga_hs_o,
  output logic                     vga_vs_o,
  output logic                     vga_blank_n_o,
  output logic                     collision_o
);

  localparam int N = NUM_SPRITES;
  localparam logic [COL_W:0] SIZE_COL = (COL_W+1)'(SPRITE_SIZE);
  localparam logic [ROW_W:0] SIZE_ROW = (ROW_W+1)'(SPRITE_SIZE);

  logic                 vs_prev_q;
  logic                 latch_d;
  logic [N-1:0]         en_q;
  logic [N*COL_W-1:0]   x_q;
  logic [N*ROW_W-1:0]   y_q;
  logic [N*15-1:0]      color_q;

  assign latch_d = ~vsync_i & vs_prev_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      vs_prev_q <= 1'b1;
      en_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      color_q   <= '0;
    end else begin
      vs_prev_q <= vsync_i;
      if (latch_d) begin
        en_q    <= sprite_en_i;
        x_q     <= sprite_x_i;
        y_q     <= sprite_y_i;
        color_q <= sprite_color_i;
      end
    end
  end

  // One extra bit on each side of the compare keeps x+SIZE from wrapping at the field edge.
  logic [N-1:0] hit_d;
  logic [COL_W:0] col_e;
  logic [ROW_W:0] row_e;
  assign col_e = {1'b0, display_col_i};
  assign row_e = {1'b0, display_row_i};

  for (genvar i = 0; i < N; i++) begin : g_hit
    logic [COL_W:0] x_e;
    logic [ROW_W:0] y_e;
    assign x_e = {1'b0, x_q[i*COL_W +: COL_W]};
    assign y_e = {1'b0, y_q[i*ROW_W +: ROW_W]};
    assign hit_d[i] = en_q[i] && (col_e >= x_e) && (col_e < x_e + SIZE_COL) &&
                      (row_e >= y_e) && (row_e < y_e + SIZE_ROW);
  end

  logic [N-1:0] hit_q;
  logic         vis_q, checker_q, hs_q, vs_q, blank_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hit_q     <= '0;
      vis_q     <= 1'b0;
      checker_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_q   <= 1'b0;
    end else begin
      hit_q     <= hit_d;
      vis_q     <= visible_i;
      checker_q <= display_col_i[CHECKER_BIT] ^ display_row_i[CHECKER_BIT];
      hs_q      <= hsync_i;
      vs_q      <= vsync_i;
      blank_q   <= hsync_i & vsync_i;
    end
  end

  logic [14:0] sel_c_d;
  logic [7:0]  r_d, g_d, b_d;

  // Scanning from the top index down lets the lowest-index hit overwrite the rest.
  always_comb begin
    sel_c_d = 15'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit_q[i]) sel_c_d = color_q[i*15 +: 15];
    end
  end

  always_comb begin
    r_d = 8'd0;
    g_d = 8'd0;
    b_d = 8'd0;
    if (vis_q) begin
      if (|hit_q) begin
        r_d = {sel_c_d[14:10], sel_c_d[14:12]};
        g_d = {sel_c_d[9:5],   sel_c_d[9:7]};
        b_d = {sel_c_d[4:0],   sel_c_d[4:2]};
      end else begin
        r_d = {bg_tint_i[8:6], {5{checker_q}}};
        g_d = {bg_tint_i[5:3], {5{checker_q}}};
        b_d = {bg_tint_i[2:0], {5{checker_q}}};
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      vga_r_o       <= 8'd0;
      vga_g_o       <= 8'd0;
      vga_b_o       <= 8'd0;
      vga_hs_o      <= 1'b1;
      vga_vs_o      <= 1'b1;
      vga_blank_n_o <= 1'b0;
    end else begin
      vga_r_o       <= r_d;
      vga_g_o       <= g_d;
      vga_b_o       <= b_d;
      vga_hs_o      <= hs_q;
      vga_vs_o      <= vs_q;
      vga_blank_n_o <= blank_q;
    end
  end

`ifdef COLLISION_DETECT_EN
  logic sticky_q, coll_q, overlap_d;
  assign overlap_d = vis_q & (|(hit_q & (hit_q - N'(1))));

  // An overlap seen on the latch cycle belongs to the frame that is just starting.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sticky_q <= 1'b0;
      coll_q   <= 1'b0;
    end else if (latch_d) begin
      coll_q   <= sticky_q;
      sticky_q <= overlap_d;
    end else if (overlap_d) begin
      sticky_q <= 1'b1;
    end
  end
  assign collision_o = coll_q;
`else
  assign collision_o = 1'b0;
`endif

endmodule
